sync_fifo_param: RTL and testbench

- Parametrised synchronous single-clock FIFO. It is the next generation of the 4-entry byte FIFO used between the UART RX/TX paths and the watch control logic.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Show-ahead read: the head entry is always visible on r_data.

---
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/sync_fifo_param.sv | 113 +++++++++++
 tb/tb_sync_fifo_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master drives requests and the slave (the FIFO) drives data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] w_data;
  logic              pop;
  logic [DATA_W-1:0] r_data;
  logic              flush;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;
  logic [CW-1:0]     hwm;

  modport master (
    output push, w_data, pop, flush, clr_err,
    input  r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, hwm
  );

  modport slave (
    input  push, w_data, pop, flush, clr_err,
    output r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, hwm
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO with occupancy, threshold flags and sticky errors.
// Define SYNC_FIFO_HWM_EN to add the high-water-mark register on bus.hwm.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     w_ptr;
  logic [AW-1:0]     r_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              ovf;
  logic              unf;
  logic              full_c;
  logic              empty_c;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_set;
  logic              unf_set;

  assign full_c  = (cnt == FULL_C);
  assign empty_c = (cnt == '0);

  // A flush swallows any request in the same cycle, including its error side effects.
  assign push_ok = bus.push & ~full_c  & ~bus.flush;
  assign pop_ok  = bus.pop  & ~empty_c & ~bus.flush;
  assign ovf_set = bus.push & full_c   & ~bus.flush;
  assign unf_set = bus.pop  & empty_c  & ~bus.flush;

  always_comb begin
    cnt_nxt = cnt;
    if (bus.flush)
      cnt_nxt = '0;
    else if (push_ok && !pop_ok)
      cnt_nxt = cnt + CW'(1);
    else if (pop_ok && !push_ok)
      cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (bus.flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (push_ok) w_ptr <= w_ptr + AW'(1);
        if (pop_ok)  r_ptr <= r_ptr + AW'(1);
      end
    end
  end

  // Storage is data-only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[w_ptr] <= bus.w_data;
  end

  // Set beats clear so an error in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)          ovf <= 1'b1;
      else if (bus.clr_err) ovf <= 1'b0;
      if (unf_set)          unf <= 1'b1;
      else if (bus.clr_err) unf <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hwm_q <= '0;
    else if (bus.clr_err)
      hwm_q <= cnt_nxt;
    else if (cnt_nxt > hwm_q)
      hwm_q <= cnt_nxt;
  end

  assign bus.hwm = hwm_q;
`else
  assign bus.hwm = '0;
`endif

  assign bus.r_data       = mem[r_ptr];
  assign bus.count        = cnt;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at default parameters: a reference queue
// tracks accepted words and the expected flag/count state after every edge.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AF_LV  = DEPTH - 2;
  localparam int AE_LV  = 2;

  logic clk = 1'b0;
  logic rst;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DATA_W-1:0] sb [$];
  logic m_ovf;
  logic m_unf;
  int   m_hwm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int exp_hwm();
`ifdef SYNC_FIFO_HWM_EN
    return m_hwm;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_hwm = 0;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, ".count"},        32'(bus.count),        32'(n));
    chk({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
    chk({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF_LV));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_LV));
    chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_unf));
    chk({tag, ".hwm"},          32'(bus.hwm),          32'(exp_hwm()));
    if (n > 0)
      chk({tag, ".r_data"},     32'(bus.r_data),       32'(sb[0]));
  endtask

  // Drive one cycle of requests, advance the reference, then check after the edge.
  task automatic cycle(input string tag, input logic ps, input logic [DATA_W-1:0] d,
                       input logic pp, input logic fl, input logic clr);
    int  n;
    logic m_full, m_empty;
    bus.push    = ps;
    bus.w_data  = d;
    bus.pop     = pp;
    bus.flush   = fl;
    bus.clr_err = clr;
    n       = sb.size();
    m_full  = (n == DEPTH);
    m_empty = (n == 0);
    if (fl) begin
      sb.delete();
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      if (pp && !m_empty) void'(sb.pop_front());
      if (ps && !m_full)  sb.push_back(d);
      if (ps && m_full)   m_ovf = 1'b1;
      else if (clr)       m_ovf = 1'b0;
      if (pp && m_empty)  m_unf = 1'b1;
      else if (clr)       m_unf = 1'b0;
    end
    if (clr)                 m_hwm = sb.size();
    else if (sb.size() > m_hwm) m_hwm = sb.size();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    bus.w_data = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    #1;
    check_state("reset");
    #2 rst = 1'b0;

    // Fill to full then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill.full_reached", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("drain.empty_end", 32'(bus.empty), 32'd1);

    // Pointer wrap-around.
    for (int i = 0; i < 10; i++) cycle("wrap_a_push", 1'b1, 8'(i + 8'h30), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("wrap_a_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle("wrap_b_push", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle("wrap_b_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("wrap.count_end", 32'(bus.count), 32'd0);

    // Push+pop on full: push rejected, head consumed.
    for (int i = 0; i < DEPTH; i++) cycle("full2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cycle("full_pushpop", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop.count15", 32'(bus.count), 32'(DEPTH - 1));
    chk("full_pushpop.head", 32'(bus.r_data), 32'h11);
    for (int i = 0; i < DEPTH - 1; i++) cycle("full_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Underflow, push+pop on empty, then clear errors.
    cycle("empty_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_pop.underflow", 32'(bus.underflow), 32'd1);
    cycle("empty_pushpop", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    chk("empty_pushpop.r_data", 32'(bus.r_data), 32'h3C);
    cycle("clr_err", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("clr_err.underflow", 32'(bus.underflow), 32'd0);

    // Error set wins over a simultaneous clear.
    cycle("pre_set_clr", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("set_clr", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("set_clr.underflow", 32'(bus.underflow), 32'd1);
    cycle("clr_err2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Flush with a concurrent push at count 9.
    for (int i = 0; i < 9; i++) cycle("pre_flush", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    cycle("flush_push", 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush.empty", 32'(bus.empty), 32'd1);
`ifdef SYNC_FIFO_HWM_EN
    chk("flush.hwm9", 32'(bus.hwm), 32'd9);
`endif
    cycle("post_flush_push", 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    cycle("post_flush_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges with count 5.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk);
    #3 rst = 1'b0;
    cycle("after_rst_push", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cycle("after_rst_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
